mem_sram_resp: RTL and testbench

- Synthesizable memory responder: the target end of the load/store request interface that the write-back/load-store stage drives.
- Replaces direct simulator memory calls with a cycle-accurate valid/ready slave backed by an internal word array.
- Adds configurable access latency, byte-strobed writes and address-range error reporting, so the core's multi-cycle memory handshake can be built and verified against it.

---
 rtl/mem_sram_resp.sv | 122 ++++++++++++
 tb/tb_mem_sram_resp.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_sram_resp.sv
// mem_sram_resp: valid/ready memory target for the load/store request path.
// One request is latched, held for LATENCY wait cycles, then answered from an
// internal word array with byte-strobed writes and out-of-range error reporting.
module mem_sram_resp #(
   parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wmask,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  LAT4      = 4'(LATENCY);
   // inclusive byte window, 33 bits wide so the top bound cannot wrap
   localparam logic [32:0] LO33      = {1'b0, ADDR_BASE};
   localparam logic [32:0] HI33      = LO33 + (33'(DEPTH_WORDS) << 2) - 33'd1;

   typedef struct packed {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } req_t;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t  state_q, state_d;
   req_t    req_q, req_in, acc;
   logic [3:0] cnt_q, cnt_d;
   logic    accept, enter_resp, in_range;
   logic [AW-1:0] idx;
   logic [NUM_LANES-1:0][7:0] wlane;
   logic [31:0] mem [DEPTH_WORDS];

   assign req_ready = (state_q == IDLE);
   assign accept    = req_valid && req_ready;
   assign req_in    = {req_wen, req_addr, req_wdata, req_wmask};

   // with zero latency the array is accessed on the acceptance edge itself,
   // before the latch holds anything, so take the live request in IDLE
   assign acc      = (state_q == IDLE) ? req_in : req_q;
   assign in_range = ({1'b0, acc.addr} >= LO33) && ({1'b0, acc.addr} <= HI33);
   assign idx      = AW'((acc.addr - ADDR_BASE) >> 2);
   assign wlane    = acc.wdata;

   // next state and wait counter
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      enter_resp = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               cnt_d = LAT4;
               if (LATENCY == 0) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // control state, request latch and response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         req_q      <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) req_q <= req_in;
         if (enter_resp) begin
            resp_valid <= 1'b1;
            resp_err   <= !in_range;
            resp_rdata <= (in_range && !acc.wen) ? mem[idx] : 32'd0;
         end else if (state_q == RESP && resp_ready) begin
            // data and error keep their last values once the handshake is done
            resp_valid <= 1'b0;
         end
      end
   end

   // byte-strobed array write; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (!rst && enter_resp && in_range && acc.wen) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (acc.wmask[i]) mem[idx][8*i +: 8] <= wlane[i];
         end
      end
   end

endmodule

// File: tb/tb_mem_sram_resp.sv
// tb_mem_sram_resp: directed plus randomized checks of mem_sram_resp against a
// word-array reference model; one instance with LATENCY=2, one with LATENCY=0.
module tb_mem_sram_resp;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk, rst;
   logic        req_valid, req_wen, resp_ready;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wmask;
   logic        sel;   // 0: LATENCY=2 instance, 1: LATENCY=0 instance

   logic        rr2, rv2, re2, rr0, rv0, re0;
   logic [31:0] rd2, rd0;
   logic        rr, rv, re;
   logic [31:0] rd;

   logic [31:0] mdl [2][1024];
   int n_vec = 0;
   int n_err = 0;

   mem_sram_resp #(.ADDR_BASE(BASE), .DEPTH_WORDS(1024), .LATENCY(2)) u_lat2 (
      .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rr2),
      .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .resp_valid(rv2), .resp_ready(resp_ready), .resp_rdata(rd2), .resp_err(re2));

   mem_sram_resp #(.ADDR_BASE(BASE), .DEPTH_WORDS(1024), .LATENCY(0)) u_lat0 (
      .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rr0),
      .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .resp_valid(rv0), .resp_ready(resp_ready), .resp_rdata(rd0), .resp_err(re0));

   assign rr = sel ? rr0 : rr2;
   assign rv = sel ? rv0 : rv2;
   assign rd = sel ? rd0 : rd2;
   assign re = sel ? re0 : re2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} <= {1'b0, BASE} + 33'd4095);
   endfunction

   // one full transaction; called and returning at #1 after a rising edge
   task automatic txn(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wmask, input int hold, input bit early);
      int cyc;
      int lat;
      int unsigned idx;
      logic        exp_e;
      logic [31:0] exp_d;
      lat = sel ? 0 : 2;
      chk("req_ready_idle", 32'(rr), 32'd1);
      req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
      resp_ready = early;
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_wmask = 4'($urandom);
      cyc = 1;
      while (!rv && cyc < 40) begin
         chk("req_ready_busy", 32'(rr), 32'd0);
         @(posedge clk); #1;
         cyc++;
      end
      chk("resp_latency", 32'(cyc), 32'(lat + 1));
      exp_e = !in_rng(addr);
      idx   = ((addr - BASE) >> 2) & 32'h3FF;
      if (!exp_e && wen)
         for (int b = 0; b < 4; b++) if (wmask[b]) mdl[sel][idx][8*b +: 8] = wdata[8*b +: 8];
      exp_d = (!exp_e && !wen) ? mdl[sel][idx] : 32'd0;
      chk("resp_err", 32'(re), 32'(exp_e));
      chk("resp_rdata", rd, exp_d);
      for (int h = 0; h < hold; h++) begin
         resp_ready = 1'b0;
         @(posedge clk); #1;
         chk("hold_valid", 32'(rv), 32'd1);
         chk("hold_rdata", rd, exp_d);
         chk("hold_err", 32'(re), 32'(exp_e));
         chk("hold_req_ready", 32'(rr), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk("post_hs_valid", 32'(rv), 32'd0);
      chk("post_hs_ready", 32'(rr), 32'd1);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      txn(1'b1, a, d, m, 0, 1'b0);
   endtask

   task automatic rd_chk(input logic [31:0] a);
      txn(1'b0, a, 32'd0, 4'd0, 0, 1'b0);
   endtask

   initial begin
      logic [31:0] oor [4];
      oor[0] = 32'h8000_1000; oor[1] = 32'h7FFF_FFFC; oor[2] = 32'hFFFF_FFFC; oor[3] = 32'h0000_0000;
      sel = 1'b0; rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; resp_ready = 1'b0;
      req_addr = 32'd0; req_wdata = 32'd0; req_wmask = 4'd0;
      for (int s = 0; s < 2; s++) for (int i = 0; i < 1024; i++) mdl[s][i] = 32'hx;

      // reset then idle
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_req_ready", 32'(rr2), 32'd1);
      chk("rst_resp_valid", 32'(rv2), 32'd0);
      chk("rst_rdata", rd2, 32'd0);
      chk("rst_err", 32'(re2), 32'd0);
      chk("rst0_req_ready", 32'(rr0), 32'd1);
      chk("rst0_resp_valid", 32'(rv0), 32'd0);

      // preload a 16-word window and the top word in both instances
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         for (int i = 0; i < 16; i++) wr(BASE + 32'(4*i), $urandom, 4'hF);
         wr(32'h8000_0FFC, $urandom, 4'hF);
      end
      sel = 1'b0;

      // write then read
      wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
      rd_chk(32'h8000_0010);

      // byte strobes, then an empty mask
      wr(32'h8000_0014, 32'h1122_3344, 4'hF);
      wr(32'h8000_0014, 32'hAABB_CCDD, 4'b0101);
      rd_chk(32'h8000_0014);
      wr(32'h8000_0014, 32'h0F0F_0F0F, 4'h0);
      rd_chk(32'h8000_0014);

      // range boundaries; out-of-range write must not alias onto word 0
      rd_chk(32'h8000_0FFC);
      for (int i = 0; i < 4; i++) rd_chk(oor[i]);
      wr(32'h8000_1000, 32'h5A5A_5A5A, 4'hF);
      rd_chk(32'h8000_0000);
      rd_chk(32'h8000_0FFC);

      // backpressure
      txn(1'b0, 32'h8000_0010, 32'd0, 4'd0, 5, 1'b0);

      // reset while waiting discards the pending write
      wr(32'h8000_0020, 32'h0000_0001, 4'hF);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020;
      req_wdata = 32'h5555_5555; req_wmask = 4'hF;
      @(posedge clk); #1;
      req_valid = 1'b0; rst = 1'b1;
      chk("wait_req_ready", 32'(rr2), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("rst_wait_valid", 32'(rv2), 32'd0);
         chk("rst_wait_ready", 32'(rr2), 32'd1);
         chk("rst_wait_rdata", rd2, 32'd0);
         @(posedge clk); #1;
      end
      rd_chk(32'h8000_0020);

      // zero-latency instance, then reset on the acceptance edge
      sel = 1'b1;
      wr(32'h8000_0030, 32'hCAFE_F00D, 4'hF);
      rd_chk(32'h8000_0030);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0030;
      req_wdata = 32'h1234_5678; req_wmask = 4'hF; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rst_acc_valid", 32'(rv0), 32'd0);
         chk("rst_acc_ready", 32'(rr0), 32'd1);
         @(posedge clk); #1;
      end
      rd_chk(32'h8000_0030);

      // randomized traffic over the preloaded window plus out-of-range hits
      for (int n = 0; n < 80; n++) begin
         logic [31:0] a;
         sel = 1'($urandom);
         if ($urandom_range(0, 7) == 0) a = oor[$urandom_range(0, 3)];
         else a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
         txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), 1'($urandom));
      end

      // final sweep: every preloaded word in both instances
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         for (int i = 0; i < 16; i++) rd_chk(BASE + 32'(4*i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
